peak_window_tracker: RTL and testbench

- Downstream consumer of the 3-input signed maximum stage.
- Takes the stream of signed 14-bit maxima plus a valid strobe and tracks the running maximum and minimum over fixed windows of WIN_LEN accepted samples.
- Emits one registered result per window, with an early-close (flush) option.
- Feeds the downstream peak/envelope logic with per-window extremes.

---
 rtl/peak_window_tracker.sv | 126 ++++++++++++
 tb/tb_peak_window_tracker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/peak_window_tracker.sv
// peak_window_tracker
// Tracks the signed maximum and minimum of a sample stream over windows of
// WIN_LEN accepted samples and emits one registered result per window.
// A window can also be closed early with i_flush.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high (wins over i_valid/i_flush)
//   i_valid  in   i_data accepted on this edge
//   i_data   in   signed WIDTH-bit sample
//   i_flush  in   close the current window early
//   o_max    out  signed maximum of the last closed window
//   o_min    out  signed minimum of the last closed window
//   o_count  out  number of samples in the last closed window
//   o_valid  out  one-cycle strobe when o_max/o_min/o_count update
//   o_busy   out  high while a window is partially filled
module peak_window_tracker #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned WIN_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_flush,
  output logic signed [WIDTH-1:0] o_max,
  output logic signed [WIDTH-1:0] o_min,
  output logic [CNT_W-1:0]        o_count,
  output logic                    o_valid,
  output logic                    o_busy
);

  localparam logic [CNT_W-1:0] LP_WIN_LEN = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_run_max;
  logic signed [WIDTH-1:0] r_run_min;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [WIDTH-1:0] r_max;
  logic signed [WIDTH-1:0] r_min;
  logic [CNT_W-1:0]        r_count;
  logic                    r_valid;
  logic                    r_busy;

  logic                    w_first;
  logic signed [WIDTH-1:0] w_nxt_max;
  logic signed [WIDTH-1:0] w_nxt_min;
  logic [CNT_W-1:0]        w_nxt_cnt;
  logic                    w_close_on_sample;

  // Extremes and count as they would be after accepting i_data this edge.
  // In IDLE the incoming sample seeds the window on its own.
  always_comb begin
    w_first   = (r_state == S_IDLE);
    w_nxt_max = r_run_max;
    w_nxt_min = r_run_min;
    w_nxt_cnt = r_cnt + LP_ONE;
    if (w_first) begin
      w_nxt_max = i_data;
      w_nxt_min = i_data;
      w_nxt_cnt = LP_ONE;
    end else begin
      if (i_data > r_run_max) w_nxt_max = i_data;
      if (i_data < r_run_min) w_nxt_min = i_data;
    end
    // A flush alongside the WIN_LEN-th sample is still one close.
    w_close_on_sample = i_flush || (w_nxt_cnt == LP_WIN_LEN);
  end

  // Window FSM with registered result and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_run_max <= '0;
      r_run_min <= '0;
      r_cnt     <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_valid) begin
        if (w_close_on_sample) begin
          r_max   <= w_nxt_max;
          r_min   <= w_nxt_min;
          r_count <= w_nxt_cnt;
          r_valid <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_run_max <= w_nxt_max;
          r_run_min <= w_nxt_min;
          r_cnt     <= w_nxt_cnt;
          r_state   <= S_ACCUM;
          r_busy    <= 1'b1;
        end
      end else if (i_flush && (r_state == S_ACCUM)) begin
        // Early close of a partial window with what is already held.
        r_max   <= r_run_max;
        r_min   <= r_run_min;
        r_count <= r_cnt;
        r_valid <= 1'b1;
        r_cnt   <= '0;
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  assign o_max   = r_max;
  assign o_min   = r_min;
  assign o_count = r_count;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_peak_window_tracker.sv
// Directed table-driven bench for peak_window_tracker with WIN_LEN=4.
module tb_peak_window_tracker;

  localparam int unsigned WIDTH   = 14;
  localparam int unsigned WIN_LEN = 4;
  localparam int unsigned CNT_W   = 8;

  logic                    clk;
  logic                    rst;
  logic                    i_valid;
  logic signed [WIDTH-1:0] i_data;
  logic                    i_flush;
  logic signed [WIDTH-1:0] o_max;
  logic signed [WIDTH-1:0] o_min;
  logic [CNT_W-1:0]        o_count;
  logic                    o_valid;
  logic                    o_busy;

  peak_window_tracker #(
    .WIDTH  (WIDTH),
    .WIN_LEN(WIN_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .i_data (i_data),
    .i_flush(i_flush),
    .o_max  (o_max),
    .o_min  (o_min),
    .o_count(o_count),
    .o_valid(o_valid),
    .o_busy (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic valid;
    logic flush;
    int   data;
    logic e_valid;
    logic e_busy;
    int   e_max;
    int   e_min;
    int   e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic f, input int d,
                              input logic ev, input logic eb, input int emax,
                              input int emin, input int ecnt);
    vec_t t;
    t.rst = r; t.valid = v; t.flush = f; t.data = d;
    t.e_valid = ev; t.e_busy = eb; t.e_max = emax; t.e_min = emin; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic f, input int d);
    @(negedge clk);
    rst     = r;
    i_valid = v;
    i_flush = f;
    i_data  = WIDTH'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input int idx, input logic ev, input logic eb,
                               input int emax, input int emin, input int ecnt);
    chk("o_valid", idx, int'(o_valid), int'(ev));
    chk("o_busy",  idx, int'(o_busy),  int'(eb));
    chk("o_max",   idx, int'(o_max),   emax);
    chk("o_min",   idx, int'(o_min),   emin);
    chk("o_count", idx, int'(o_count), ecnt);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_data = '0;

    // reset held with valid+flush asserted
    vecs.push_back(mk(1,1,1,100,   0,0,0,0,0));
    vecs.push_back(mk(1,1,1,100,   0,0,0,0,0));
    // 5,-3,12,7
    vecs.push_back(mk(0,1,0,5,     0,1,0,0,0));
    vecs.push_back(mk(0,1,0,-3,    0,1,0,0,0));
    vecs.push_back(mk(0,1,0,12,    0,1,0,0,0));
    vecs.push_back(mk(0,1,0,7,     1,0,12,-3,4));
    vecs.push_back(mk(0,0,0,0,     0,0,12,-3,4));
    // back-to-back full-range windows
    vecs.push_back(mk(0,1,0,8191,  0,1,12,-3,4));
    vecs.push_back(mk(0,1,0,-8192, 0,1,12,-3,4));
    vecs.push_back(mk(0,1,0,0,     0,1,12,-3,4));
    vecs.push_back(mk(0,1,0,1,     1,0,8191,-8192,4));
    vecs.push_back(mk(0,1,0,2,     0,1,8191,-8192,4));
    vecs.push_back(mk(0,1,0,2,     0,1,8191,-8192,4));
    vecs.push_back(mk(0,1,0,2,     0,1,8191,-8192,4));
    vecs.push_back(mk(0,1,0,2,     1,0,2,2,4));
    // gapped negative samples
    vecs.push_back(mk(0,1,0,-1,    0,1,2,2,4));
    vecs.push_back(mk(0,0,0,99,    0,1,2,2,4));
    vecs.push_back(mk(0,1,0,-2,    0,1,2,2,4));
    vecs.push_back(mk(0,0,0,99,    0,1,2,2,4));
    vecs.push_back(mk(0,1,0,-3,    0,1,2,2,4));
    vecs.push_back(mk(0,0,0,99,    0,1,2,2,4));
    vecs.push_back(mk(0,1,0,-4,    1,0,-1,-4,4));
    vecs.push_back(mk(0,0,0,0,     0,0,-1,-4,4));
    // flush together with a sample, then flush alone in IDLE
    vecs.push_back(mk(0,1,0,10,    0,1,-1,-4,4));
    vecs.push_back(mk(0,1,0,20,    0,1,-1,-4,4));
    vecs.push_back(mk(0,1,1,30,    1,0,30,10,3));
    vecs.push_back(mk(0,0,1,0,     0,0,30,10,3));
    vecs.push_back(mk(0,0,0,0,     0,0,30,10,3));
    // reset mid-window discards partial window
    vecs.push_back(mk(0,1,0,50,    0,1,30,10,3));
    vecs.push_back(mk(0,1,0,60,    0,1,30,10,3));
    vecs.push_back(mk(0,1,0,70,    0,1,30,10,3));
    vecs.push_back(mk(1,0,0,0,     0,0,0,0,0));
    vecs.push_back(mk(0,1,0,1,     0,1,0,0,0));
    vecs.push_back(mk(0,1,0,2,     0,1,0,0,0));
    vecs.push_back(mk(0,1,0,3,     0,1,0,0,0));
    vecs.push_back(mk(0,1,0,4,     1,0,4,1,4));
    vecs.push_back(mk(0,0,0,0,     0,0,4,1,4));
    // valid+flush in IDLE: immediate 1-sample window
    vecs.push_back(mk(0,1,1,-8192, 1,0,-8192,-8192,1));
    vecs.push_back(mk(0,0,0,0,     0,0,-8192,-8192,1));
    // flush with the WIN_LEN-th sample: single close, equal values
    vecs.push_back(mk(0,1,0,3,     0,1,-8192,-8192,1));
    vecs.push_back(mk(0,1,0,3,     0,1,-8192,-8192,1));
    vecs.push_back(mk(0,1,0,3,     0,1,-8192,-8192,1));
    vecs.push_back(mk(0,1,1,3,     1,0,3,3,4));
    vecs.push_back(mk(0,0,0,0,     0,0,3,3,4));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].flush, vecs[i].data);
      check_outputs(i, vecs[i].e_valid, vecs[i].e_busy,
                    vecs[i].e_max, vecs[i].e_min, vecs[i].e_cnt);
    end

    // Long gap inside a window, then a flush with no sample.
    step(0, 1, 0, 7);
    step(0, 1, 0, -5);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 0);
      if (k == 0 || k == 19) check_outputs(1000 + k, 0, 1, 3, 3, 4);
    end
    step(0, 0, 1, 0);
    check_outputs(2000, 1, 0, 7, -5, 2);
    step(0, 0, 0, 0);
    check_outputs(2001, 0, 0, 7, -5, 2);

    // New window after flush; wait for its strobe with a bounded budget.
    step(0, 1, 0, -100);
    step(0, 1, 0, 100);
    step(0, 1, 0, 0);
    step(0, 1, 0, -100);
    begin
      int waited;
      waited = 0;
      while (o_valid !== 1'b1 && waited < 5) begin
        step(0, 0, 0, 0);
        waited++;
      end
      chk("strobe_latency", 3000, waited, 0);
      check_outputs(3001, 1, 0, 100, -100, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
